// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared state encoding and operand width for the shift-add multiplier
package multiplier_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADD,
    SHIFT,
    HALT
  } mult_state_t;

endpackage

// File: rtl/mult_iter_counter.sv
// rtl/mult_iter_counter.sv - iteration counter with clear, increment and terminal count
module mult_iter_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multiplier_control.sv
// rtl/multiplier_control.sv - sequencer issuing clear/add/sub/shift strobes for one signed multiply per Run press
module multiplier_control
  import multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             M,
  output logic             Clr_Ld,
  output logic             Clr_XA,
  output logic             Add,
  output logic             Sub,
  output logic             Shift,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Iter
);

  mult_state_t      state;
  logic [CNT_W-1:0] count;
  logic             last_iter;
  logic             cnt_clr;
  logic             cnt_inc;

  // Counter is zeroed on entering an iteration run and again when leaving HALT,
  // so Iter reads 0 in IDLE and WIDTH-1 while the product is held.
  assign cnt_clr = (state == START) || ((state == HALT) && !Run);
  assign cnt_inc = (state == SHIFT) && !last_iter;

  mult_iter_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_iter (
    .clk   (Clk),
    .resetn(Reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (count),
    .tc    (last_iter)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (Run) state <= START;
        START:   state <= ADD;
        ADD:     state <= SHIFT;
        SHIFT:   state <= last_iter ? HALT : ADD;
        HALT:    if (!Run) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset gates every output so an aborted multiply stops strobing the datapath at once.
  assign Clr_Ld = Reset && (state == IDLE) && ClearA_LoadB && !Run;
  assign Clr_XA = Reset && (state == START);
  assign Add    = Reset && (state == ADD) && M && !last_iter;
  assign Sub    = Reset && (state == ADD) && M && last_iter;
  assign Shift  = Reset && (state == SHIFT);
  assign Busy   = Reset && ((state == START) || (state == ADD) || (state == SHIFT));
  assign Done   = Reset && (state == HALT);
  assign Iter   = Reset ? count : '0;

endmodule
